csr_unit: RTL
=============

# csr_unit

Machine-mode CSR unit for the single-cycle core, replacing the fixed four-register CSR block. Executes CSRRW/CSRRS/CSRRC, ECALL, EBREAK and MRET. Adds MIE/MPIE stacking, a machine timer interrupt, illegal-access traps and 64-bit cycle/instret counters. Sits beside the register file; its `trap_pc` feeds the next-PC mux.

## Interface
- `XLEN`, 32: data width; only 32 is supported for counter high halves (`mcycleh`/`minstreth`).
- `RESET_MTVEC`, 32'h8000_0000: `mtvec` reset value.
- `HART_ID`, 0: value read from `mhartid`.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `pc` in XLEN: PC of the instruction in execute.
- `op` in 3: 000 none, 001 rw, 010 rs, 011 rc, 100 ecall, 101 ebreak, 110 mret, 111 reserved (treated as none).
- `addr` in 12: CSR address.
- `wdata` in XLEN: rs1 value or zero-extended immediate.
- `retire` in 1: instruction in execute completes this cycle.
- `irq_timer` in 1: level-sensitive machine timer interrupt request.
- `rdata` out XLEN: old CSR value, for writeback to rd.
- `trap_valid` out 1: redirect the PC to `trap_pc` this cycle and suppress the rd write.
- `trap_pc` out XLEN: redirect target.
- `illegal` out 1: illegal CSR access detected this cycle.

## Operation
- **Implemented CSRs:**
  - `mstatus` (0x300): MIE is bit 3, MPIE is bit 7, MPP (12:11) is hardwired to 11, other bits read 0.
  - `mie` (0x304): only MTIE (bit 7) is writable.
  - `mtvec` (0x305): bits 1:0 read 0; direct mode only.
  - `mscratch` (0x340): fully writable.
  - `mepc` (0x341): bits 1:0 read 0.
  - `mcause` (0x342): fully writable.
  - `mip` (0x344): read-only; MTIP is bit 7 and mirrors `irq_timer`.
  - `mcycle`/`mcycleh` (0xB00/0xB80) and `minstret`/`minstreth` (0xB02/0xB82): read/write.
  - `mhartid` (0xF14): read-only.
- **Write value:**
  - rw: `wdata`.
  - rs: `old | wdata`.
  - rc: `old & ~wdata`.
  - rs/rc with `wdata`==0 perform no write and no write-side check.
- **Illegal access:** an unimplemented address with op rw/rs/rc, or a write to a read-only CSR (`addr[11:10]`==11 or `mip`).
  - Asserts `illegal` and traps with cause 2.
  - No CSR is written.
- **Trap sources, in priority order:**
  1. Interrupt: MIE & MTIE & `irq_timer`, any op. Cause 0x8000_0007.
  2. Illegal access: cause 2.
  3. ebreak: cause 3.
  4. ecall: cause 11.
- **On a trap:**
  - `mepc` <= `pc`, `mcause` <= cause, MPIE <= MIE, MIE <= 0.
  - `trap_pc` = current `mtvec`.
  - The op's own CSR write is suppressed.
  - `retire` is ignored for `minstret`.
- **mret (no interrupt pending):** `trap_valid`=1, `trap_pc`=`mepc`, MIE <= MPIE, MPIE <= 1.
- **Counters:**
  - `mcycle` increments every cycle; `minstret` increments when `retire` & ~`trap_valid`.
  - Carry from the low word into the high word.
  - A CSR write to either half in the same cycle wins over the increment for the whole 64-bit value (the other half holds).

## Timing
- `rdata`, `trap_valid`, `trap_pc` and `illegal` are combinational from the current inputs and state.
- All state updates on the rising edge of `clk`; a read in the same cycle as a write returns the old value.
- **Reset values:**
  - `mstatus` = 0x0000_1800.
  - `mtvec` = `RESET_MTVEC`.
  - All other CSRs and both counters = 0.
  - `rst` overrides every write, trap and increment in that cycle.
- Outputs during reset follow the combinational rules on reset state; `trap_valid` may be asserted and is ignored by the core.
- **Counter wrap:** 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- **Timer interrupt:**
  - Taken in the first cycle MIE & MTIE & `irq_timer` holds.
  - Not taken again until software re-enables MIE, since MIE clears on entry.
- Interrupt coincident with mret: the interrupt wins, and `mepc` = `pc` of the mret.

## Structure
- Package `csr_pkg`:
  - CSR address constants.
  - `op` encodings.
  - Cause codes (2, 3, 11, 0x8000_0007).
  - `mstatus`/`mie`/`mip` bit positions.
- Sub-module `csr_counter64`, instantiated twice (`mcycle`, `minstret`):
  - Inputs: `inc`, `wr_lo`, `wr_hi`, `wdata`.
  - Outputs: `lo`, `hi`.
  - Carry and write-priority logic lives inside it.

## Test plan
- After reset, read 0x300 -> `rdata`=0x1800; read 0x305 -> `RESET_MTVEC`; `illegal`=0.
- csrrw 0x305 with 0x8000_0103, then read -> 0x8000_0100.
  - csrrs 0x340 with 0xF0 over 0x0F -> 0xFF.
  - csrrc with 0x0F -> 0xF0.
- ecall at `pc`=0x8000_0040 with `mtvec`=0x8000_0100:
  - Same cycle: `trap_pc`=0x8000_0100.
  - Next cycle: `mepc`=0x8000_0040, `mcause`=11.
  - mret -> `trap_pc`=0x8000_0040.
- MIE=1, MTIE=1, `irq_timer`=1 during a csrrw to `mscratch`:
  - `mscratch` unchanged, `mcause`=0x8000_0007, MIE=0, MPIE=1.
  - mret restores MIE=1.
- csrrw 0xF14 -> `illegal`=1, `mcause`=2.
  - csrrs 0xF14 with `wdata`=0 -> reads `HART_ID`, no trap.
- csrrw `mcycle` with 0xFFFF_FFFF, `mcycleh` 0 -> after 1 cycle `mcycleh`=1 and `mcycle`=0.
  - Write-vs-increment collision: the written value holds.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: addresses, op encodings,
// trap causes and status/interrupt bit positions.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [2:0] {
        OP_NONE   = 3'b000,
        OP_RW     = 3'b001,
        OP_RS     = 3'b010,
        OP_RC     = 3'b011,
        OP_ECALL  = 3'b100,
        OP_EBREAK = 3'b101,
        OP_MRET   = 3'b110,
        OP_RSVD   = 3'b111
    } csr_op_e;

    localparam logic [31:0] CAUSE_ILLEGAL   = 32'd2;
    localparam logic [31:0] CAUSE_BREAK     = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M   = 32'd11;
    localparam logic [31:0] CAUSE_TIMER_IRQ = 32'h8000_0007;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MIE_MTIE       = 7;
    localparam int MIP_MTIP       = 7;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter split into two words. A write to either half replaces the
// increment for that cycle; the other half holds its value.
module csr_counter64 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         wr_lo,
    input  logic         wr_hi,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic [2*W-1:0] next_count;

    assign next_count = {hi, lo} + {{(2*W-1){1'b0}}, 1'b1};

    // Counter update: reset, then CSR writes, then increment with carry
    always_ff @(posedge clk) begin
        if (rst) begin
            lo <= '0;
            hi <= '0;
        end else if (wr_lo) begin
            lo <= wdata;
        end else if (wr_hi) begin
            hi <= wdata;
        end else if (inc) begin
            lo <= next_count[W-1:0];
            hi <= next_count[2*W-1:W];
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSR read/modify/write, trap entry/return, timer
// interrupt and 64-bit cycle/instret counters.
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h8000_0000,
    parameter logic [XLEN-1:0] HART_ID     = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic [2:0]      op,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            retire,
    input  logic            irq_timer,
    output logic [XLEN-1:0] rdata,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_pc,
    output logic            illegal
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

    logic            mie_q, mpie_q, mtie_q;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [XLEN-1:0] cyc_lo, cyc_hi, ins_lo, ins_hi;

    csr_op_e         op_e;
    logic            is_csr, wr_req, hit, read_only;
    logic            irq_take, exc, is_mret, csr_we;
    logic [XLEN-1:0] old_val, new_val, cause, mstatus_rd;

    assign op_e    = csr_op_e'(op);
    assign is_csr  = (op_e == OP_RW) || (op_e == OP_RS) || (op_e == OP_RC);
    // rs/rc with a zero mask are pure reads: no write and no write-side check
    assign wr_req  = (op_e == OP_RW) || (is_csr && (wdata != '0));
    assign is_mret = (op_e == OP_MRET);

    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_rd[MSTATUS_MPIE] = mpie_q;
        mstatus_rd[MSTATUS_MIE]  = mie_q;
    end

    // CSR read mux; hit flags whether the address is implemented
    always_comb begin
        old_val = '0;
        hit     = 1'b1;
        case (addr)
            CSR_MSTATUS:   old_val = mstatus_rd;
            CSR_MIE:       old_val[MIE_MTIE] = mtie_q;
            CSR_MTVEC:     old_val = mtvec_q;
            CSR_MSCRATCH:  old_val = mscratch_q;
            CSR_MEPC:      old_val = mepc_q;
            CSR_MCAUSE:    old_val = mcause_q;
            CSR_MIP:       old_val[MIP_MTIP] = irq_timer;
            CSR_MCYCLE:    old_val = cyc_lo;
            CSR_MCYCLEH:   old_val = cyc_hi;
            CSR_MINSTRET:  old_val = ins_lo;
            CSR_MINSTRETH: old_val = ins_hi;
            CSR_MHARTID:   old_val = HART_ID;
            default:       hit = 1'b0;
        endcase
    end

    // New CSR value for rw / rs / rc
    always_comb begin
        new_val = wdata;
        if (op_e == OP_RS) new_val = old_val | wdata;
        if (op_e == OP_RC) new_val = old_val & ~wdata;
    end

    assign read_only = (addr[11:10] == 2'b11) || (addr == CSR_MIP);
    assign illegal   = is_csr && (!hit || (wr_req && read_only));
    assign irq_take  = mie_q && mtie_q && irq_timer;
    assign exc       = irq_take || illegal || (op_e == OP_EBREAK) || (op_e == OP_ECALL);
    assign csr_we    = is_csr && wr_req && !exc;

    assign rdata      = old_val;
    assign trap_valid = exc || is_mret;
    assign trap_pc    = (is_mret && !exc) ? mepc_q : mtvec_q;

    // Trap cause in priority order
    always_comb begin
        cause = CAUSE_ECALL_M;
        if (irq_take)                 cause = CAUSE_TIMER_IRQ;
        else if (illegal)             cause = CAUSE_ILLEGAL;
        else if (op_e == OP_EBREAK)   cause = CAUSE_BREAK;
    end

    // CSR state: trap entry and mret take precedence over the op's own write
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtie_q     <= 1'b0;
            mtvec_q    <= RESET_MTVEC & ALIGN_MASK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (exc) begin
            mepc_q   <= pc & ALIGN_MASK;
            mcause_q <= cause;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (is_mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (csr_we) begin
            case (addr)
                CSR_MSTATUS: begin
                    mie_q  <= new_val[MSTATUS_MIE];
                    mpie_q <= new_val[MSTATUS_MPIE];
                end
                CSR_MIE:      mtie_q     <= new_val[MIE_MTIE];
                CSR_MTVEC:    mtvec_q    <= new_val & ALIGN_MASK;
                CSR_MSCRATCH: mscratch_q <= new_val;
                CSR_MEPC:     mepc_q     <= new_val & ALIGN_MASK;
                CSR_MCAUSE:   mcause_q   <= new_val;
                default: ;
            endcase
        end
    end

    csr_counter64 #(.W(XLEN)) u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (csr_we && (addr == CSR_MCYCLE)),
        .wr_hi (csr_we && (addr == CSR_MCYCLEH)),
        .wdata (new_val),
        .lo    (cyc_lo),
        .hi    (cyc_hi)
    );

    csr_counter64 #(.W(XLEN)) u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire && !trap_valid),
        .wr_lo (csr_we && (addr == CSR_MINSTRET)),
        .wr_hi (csr_we && (addr == CSR_MINSTRETH)),
        .wdata (new_val),
        .lo    (ins_lo),
        .hi    (ins_hi)
    );

endmodule
